// File: rtl/des_pkg.sv
// Shared DES block constants, packer state encoding and bit-order helper.
// Imported by the block packer and its interface.
package des_pkg;

  localparam int DES_BLK_W     = 64;
  localparam int DES_BLK_BYTES = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } packer_state_t;

  // Reverses bit order so byte bit 7 lands on the lowest DES bit index of its lane.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_block_packer_if.sv
// Byte-in / block-out handshake bundle of the DES block packer.
// The packer takes the slave side; the byte source and block consumer take master.
interface des_block_packer_if;
  import des_pkg::*;

  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [DES_BLK_W-1:0] out_block;
  logic [3:0]           out_nbytes;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_block, out_nbytes, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_nbytes, out_last, out_valid
  );

endinterface

// File: rtl/des_block_packer.sv
// Packs a byte stream into 64-bit DES blocks (DES bit numbering) with optional
// PKCS#5 padding; one output holding register, valid/ready on both sides.
module des_block_packer
  import des_pkg::*;
#(
  parameter bit PAD_EN     = 1'b1,
  parameter bit DES_BITORD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  des_block_packer_if.slave bus
);

  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_PAD  = PAD;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]           state_reg;
  logic [2:0]           cnt_reg;
  logic [DES_BLK_W-1:0] block_reg;
  logic [DES_BLK_W-1:0] block_next;
  logic [3:0]           nbytes_reg;
  logic                 last_reg;
  logic                 pad_pending_reg;

  logic                 in_xfer;
  logic                 out_xfer;
  logic [7:0]           pad_byte;
  logic [7:0]           data_lane;
  logic [7:0]           pad_lane;
  logic [7:0]           full_pad_lane;

  function automatic logic [7:0] lane_ord(input logic [7:0] b);
    return DES_BITORD ? bitrev8(b) : b;
  endfunction

  assign bus.in_ready = (state_reg == ST_FILL) & ~rst;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = (state_reg == ST_HOLD) & bus.out_ready;

  // PKCS#5 pad value is the number of pad bytes; cnt is 1..7 while in PAD.
  assign pad_byte      = PAD_EN ? {4'd0, 4'd8 - {1'b0, cnt_reg}} : 8'h00;
  assign data_lane     = lane_ord(bus.in_data);
  assign pad_lane      = lane_ord(pad_byte);
  assign full_pad_lane = lane_ord(8'h08);

  generate
    for (genvar gi = 0; gi < DES_BLK_BYTES; gi++) begin : g_lane
      assign block_next[8*gi +: 8] =
          (in_xfer && cnt_reg == 3'(gi))                 ? data_lane     :
          (state_reg == ST_PAD && 3'(gi) >= cnt_reg)     ? pad_lane      :
          (out_xfer && pad_pending_reg)                  ? full_pad_lane :
                                                           block_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_FILL;
      cnt_reg         <= 3'd0;
      block_reg       <= '0;
      nbytes_reg      <= 4'd0;
      last_reg        <= 1'b0;
      pad_pending_reg <= 1'b0;
    end else begin
      block_reg <= block_next;
      case (state_reg)
        ST_FILL: begin
          if (in_xfer) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              // Full block: with padding, a last-byte block is followed by a full pad block.
              state_reg       <= ST_HOLD;
              nbytes_reg      <= 4'd8;
              last_reg        <= PAD_EN ? 1'b0 : bus.in_last;
              pad_pending_reg <= PAD_EN ? bus.in_last : 1'b0;
            end else if (bus.in_last) begin
              state_reg <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          nbytes_reg <= {1'b0, cnt_reg};
          last_reg   <= 1'b1;
          state_reg  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            cnt_reg <= 3'd0;
            if (pad_pending_reg) begin
              nbytes_reg      <= 4'd0;
              last_reg        <= 1'b1;
              pad_pending_reg <= 1'b0;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        default: state_reg <= ST_FILL;
      endcase
    end
  end

  assign bus.out_block  = block_reg;
  assign bus.out_nbytes = nbytes_reg;
  assign bus.out_last   = last_reg;
  assign bus.out_valid  = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: table of messages with known blocks, scoreboard
// queues per instance (PAD_EN=1 and PAD_EN=0), plus latency/stall/reset sequences.
module tb_des_block_packer;

  typedef struct {
    logic [63:0] blk;
    logic [3:0]  nb;
    logic        last;
  } exp_t;

  typedef struct {
    bit          sel;      // 0 = padding instance, 1 = zero-fill instance
    int          len;
    logic [63:0] bytes;    // byte k at [8k +: 8]
    logic        lastflag;
    logic [63:0] blk;
    logic [3:0]  nb;
    logic        last;
    bit          padblk;   // a full 0x08 pad block follows
  } vec_t;

  localparam logic [63:0] PAD_BLOCK = 64'h1010101010101010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  des_block_packer_if ifa ();
  des_block_packer_if ifb ();

  des_block_packer #(.PAD_EN(1'b1), .DES_BITORD(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  des_block_packer #(.PAD_EN(1'b0), .DES_BITORD(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      ifb.in_valid = v; ifb.in_data = d; ifb.in_last = l;
    end else begin
      ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  task automatic push_exp(input bit sel, input logic [63:0] blk, input logic [3:0] nb, input logic l);
    exp_t e;
    e.blk = blk; e.nb = nb; e.last = l;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
    int t;
    t = 0;
    set_in(sel, 1'b1, d, l);
    while (!get_ready(sel) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", {63'd0, get_ready(sel)}, 64'd1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_bytes(input bit sel, input logic [63:0] bytes, input int len, input logic l);
    for (int k = 0; k < len; k++) begin
      send_byte(sel, bytes[8*k +: 8], l && (k == len - 1));
    end
  endtask

  task automatic check_blk(input bit sel, input logic [63:0] blk, input logic [3:0] nb, input logic l);
    exp_t e;
    $display("blk dut%0d: block=%h nbytes=%0d last=%0b", sel, blk, nb, l);
    if ((sel && qb.size() == 0) || (!sel && qa.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_block dut%0d: got %h, expected no block", sel, blk);
    end else begin
      if (sel) e = qb.pop_front();
      else     e = qa.pop_front();
      chk("out_block", blk, e.blk);
      chk("out_nbytes", {60'd0, nb}, {60'd0, e.nb});
      chk("out_last", {63'd0, l}, {63'd0, e.last});
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready)
      check_blk(1'b0, ifa.out_block, ifa.out_nbytes, ifa.out_last);
    if (!rst && ifb.out_valid && ifb.out_ready)
      check_blk(1'b1, ifb.out_block, ifb.out_nbytes, ifb.out_last);
  end

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8, 64'h0807060504030201, 1'b0, 64'h10E060A020C04080, 4'd8, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3, 64'h0000000000CCBBAA, 1'b1, 64'hA0A0A0A0A033DD55, 4'd3, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8, 64'h0807060504030201, 1'b1, 64'h10E060A020C04080, 4'd8, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1, 64'h0000000000000001, 1'b1, 64'hE0E0E0E0E0E0E080, 4'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 7, 64'h0007060504030201, 1'b1, 64'h80E060A020C04080, 4'd7, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 3, 64'h0000000000CCBBAA, 1'b1, 64'h000000000033DD55, 4'd3, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8, 64'h0807060504030201, 1'b1, 64'h10E060A020C04080, 4'd8, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1, 64'h0000000000000001, 1'b1, 64'h0000000000000080, 4'd1, 1'b1, 1'b0};

    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, ifa.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, ifa.in_ready}, 64'd0);
    chk("rst_out_block", ifa.out_block, 64'd0);
    chk("rst_out_nbytes", {60'd0, ifa.out_nbytes}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, ifa.in_ready}, 64'd1);

    // Table-driven messages
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].sel, vecs[i].blk, vecs[i].nb, vecs[i].last);
      if (vecs[i].padblk) push_exp(vecs[i].sel, PAD_BLOCK, 4'd0, 1'b1);
      send_bytes(vecs[i].sel, vecs[i].bytes, vecs[i].len, vecs[i].lastflag);
      drain();
    end

    // Full-block latency: out_valid right after the 8th-byte edge
    push_exp(1'b0, 64'h10E060A020C04080, 4'd8, 1'b0);
    send_bytes(1'b0, 64'h0807060504030201, 8, 1'b0);
    chk("lat_full_valid", {63'd0, ifa.out_valid}, 64'd1);
    drain();

    // Short-block latency: one PAD cycle, then HOLD
    push_exp(1'b0, 64'hA0A0A0A0A033DD55, 4'd3, 1'b1);
    send_bytes(1'b0, 64'h0000000000CCBBAA, 3, 1'b1);
    chk("lat_short_pad_valid", {63'd0, ifa.out_valid}, 64'd0);
    chk("lat_short_pad_ready", {63'd0, ifa.in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("lat_short_hold_valid", {63'd0, ifa.out_valid}, 64'd1);
    drain();

    // Back-pressure: 20 stalled HOLD cycles with a byte offered
    ifa.out_ready = 1'b0;
    push_exp(1'b0, 64'h10E060A020C04080, 4'd8, 1'b0);
    send_bytes(1'b0, 64'h0807060504030201, 8, 1'b0);
    set_in(1'b0, 1'b1, 8'h5A, 1'b1);
    for (int c = 0; c < 20; c++) begin
      chk("stall_valid", {63'd0, ifa.out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, ifa.in_ready}, 64'd0);
      chk("stall_block", ifa.out_block, 64'h10E060A020C04080);
      @(posedge clk); #1;
    end
    push_exp(1'b0, 64'hE0E0E0E0E0E0E05A, 4'd1, 1'b1);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {63'd0, ifa.in_ready}, 64'd1);
    chk("release_out_valid", {63'd0, ifa.out_valid}, 64'd0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    drain();

    // Reset while holding a block
    ifa.out_ready = 1'b0;
    send_bytes(1'b0, 64'hFFFFFFFFFFFFFFFF, 8, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_block", ifa.out_block, 64'd0);
    chk("rst_hold_valid", {63'd0, ifa.out_valid}, 64'd0);
    chk("rst_hold_nbytes", {60'd0, ifa.out_nbytes}, 64'd0);
    chk("rst_hold_in_ready", {63'd0, ifa.in_ready}, 64'd0);
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-block discards partial bytes
    send_bytes(1'b0, 64'h000000EEDDCCBBAA, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_block", ifa.out_block, 64'd0);
    chk("rst_mid_last", {63'd0, ifa.out_last}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(1'b0, 64'h10E060A020C04080, 4'd8, 1'b0);
    send_bytes(1'b0, 64'h0807060504030201, 8, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
